// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUcontrol codes, FSM state encoding, op helpers.
package alu_pkg;

  localparam int unsigned ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  // True for the ops handled by the iterative shifter.
  function automatic logic is_shift_op(input logic [ALU_CTRL_W-1:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// One-bit-per-cycle logical shifter: working register, down-counter, direction.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             dir_left_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   amt_i,
  output logic [WIDTH-1:0] step_data_c_o,
  output logic             last_c_o
);

  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q,  cnt_d;
  logic             left_q, left_d;

  // Value the working register takes after one more shift step.
  always_comb begin
    step_data_c_o = left_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};
    last_c_o      = (cnt_q == SHW'(1));
  end

  // Load on accept, otherwise shift and count down while stepping.
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    left_d = left_q;
    if (load_i) begin
      work_d = data_i;
      cnt_d  = amt_i;
      left_d = dir_left_i;
    end else if (step_i && (cnt_q != '0)) begin
      work_d = step_data_c_o;
      cnt_d  = cnt_q - SHW'(1);
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      work_q <= '0;
      cnt_q  <= '0;
      left_q <= 1'b0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      left_q <= left_d;
    end
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle logic/arith, iterative SLL/SRL, start/done handshake.
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ALU_CTRL_W-1:0] ALUcontrol,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic                  ready,
  output logic                  done,
  output logic [WIDTH-1:0]      result,
  output logic                  zero
);

  alu_state_e       state_q, state_d;
  logic             ready_q, ready_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q,  zero_d;

  logic             accept_c;
  logic [SHW-1:0]   amt_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             sh_load_c;
  logic             sh_step_c;
  logic             sh_left_c;
  logic [WIDTH-1:0] sh_step_data_c;
  logic             sh_last_c;

  assign accept_c = start && ready_q;
  assign amt_c    = b[SHW-1:0];

  alu_shift_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shift (
    .clk           (clk),
    .reset         (reset),
    .load_i        (sh_load_c),
    .step_i        (sh_step_c),
    .dir_left_i    (sh_left_c),
    .data_i        (a),
    .amt_i         (amt_c),
    .step_data_c_o (sh_step_data_c),
    .last_c_o      (sh_last_c)
  );

  // Single-cycle datapath; unlisted codes yield zero.
  always_comb begin
    alu_res_c = '0;
    case (ALUcontrol)
      ALU_AND: alu_res_c = a & b;
      ALU_OR:  alu_res_c = a | b;
      ALU_ADD: alu_res_c = a + b;
      ALU_SUB: alu_res_c = a - b;
      ALU_XOR: alu_res_c = a ^ b;
      default: alu_res_c = '0;
    endcase
  end

  // Next-state and output-register logic; result/zero only move when entering DONE.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    sh_load_c = 1'b0;
    sh_step_c = 1'b0;
    sh_left_c = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept_c) begin
          if (is_shift_op(ALUcontrol)) begin
            sh_load_c = 1'b1;
            sh_left_c = (ALUcontrol == ALU_SLL);
            if (amt_c == '0) begin
              state_d  = ST_DONE;
              result_d = a;
            end else begin
              state_d  = ST_SHIFT;
            end
          end else begin
            state_d  = ST_DONE;
            result_d = alu_res_c;
          end
        end
      end
      ST_SHIFT: begin
        sh_step_c = 1'b1;
        if (sh_last_c) begin
          state_d  = ST_DONE;
          result_d = sh_step_data_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_DONE) begin
      zero_d = (result_d == '0);
    end
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d != ST_SHIFT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed self-checking bench for alu_seq_exec.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ALUcontrol;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  alu_seq_exec #(.WIDTH(32), .SHW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ALUcontrol (ALUcontrol),
    .a          (a),
    .b          (b),
    .ready      (ready),
    .done       (done),
    .result     (result),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for done, check latency, ready-low cycles, result, zero, one-cycle done.
  task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [31:0] av,
                        input logic [31:0] bv, input int exp_lat, input int exp_rdy_low,
                        input logic [31:0] exp_res, input logic exp_zero);
    int lat;
    int rdy_low;
    ALUcontrol = ctrl; a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    ALUcontrol = 4'b0000; a = 32'h5A5A_5A5A; b = 32'hA5A5_A5A5;
    lat = 1;
    rdy_low = 0;
    while (!done && lat < 40) begin
      if (!ready) rdy_low++;
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdylow"}, 32'(rdy_low), 32'(exp_rdy_low));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
    tick();
    check({tag, "_donepulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dones;
    int lat;
    reset = 1'b1; start = 1'b0; ALUcontrol = '0; a = '0; b = '0;
    #1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);

    run_op("add",     4'b0010, 32'd5,          32'd7,          1,  0,  32'd12,         1'b0);
    run_op("sub_eq",  4'b0110, 32'd9,          32'd9,          1,  0,  32'd0,          1'b1);
    run_op("sub_neg", 4'b0110, 32'd0,          32'd1,          1,  0,  32'hFFFF_FFFF,  1'b0);
    run_op("add_wrap",4'b0010, 32'hFFFF_FFFF,  32'd2,          1,  0,  32'd1,          1'b0);
    run_op("sll4",    4'b0011, 32'h0000_0001,  32'd4,          5,  4,  32'h0000_0010,  1'b0);
    run_op("srl31",   4'b0100, 32'h8000_0000,  32'd31,         32, 31, 32'h0000_0001,  1'b0);
    run_op("sll0",    4'b0011, 32'hDEAD_BEEF,  32'h0000_0020,  1,  0,  32'hDEAD_BEEF,  1'b0);
    run_op("sll_out", 4'b0011, 32'h8000_0001,  32'd1,          2,  1,  32'h0000_0002,  1'b0);
    run_op("or",      4'b0001, 32'h0000_00F0,  32'h0000_000F,  1,  0,  32'h0000_00FF,  1'b0);
    run_op("xor",     4'b1001, 32'h0000_00FF,  32'h0000_000F,  1,  0,  32'h0000_00F0,  1'b0);

    // Start pulses during SHIFT must be ignored.
    ALUcontrol = 4'b0011; a = 32'd3; b = 32'd8; start = 1'b1;
    tick();
    ALUcontrol = 4'b1001; a = 32'd1; b = 32'd1;
    dones = 0;
    lat = 1;
    for (int i = 0; i < 5; i++) begin
      if (done) dones++;
      tick();
      lat++;
    end
    start = 1'b0;
    check("ign_hold_res", result, 32'h0000_00F0);
    check("ign_ready", 32'(ready), 32'd0);
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check("ign_lat", 32'(lat), 32'd9);
    check("ign_res", result, 32'h0000_0300);
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      tick();
    end
    check("ign_dones", 32'(dones), 32'd1);

    // Back-to-back: AND issued in the DONE cycle of an SRL.
    ALUcontrol = 4'b0100; a = 32'h0000_0100; b = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("b2b_srl_done", 32'(done), 32'd1);
    check("b2b_srl_res", result, 32'h0000_0040);
    ALUcontrol = 4'b0000; a = 32'h0000_00F0; b = 32'h0000_003C; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_and_done", 32'(done), 32'd1);
    check("b2b_and_res", result, 32'h0000_0030);
    tick();
    check("b2b_and_pulse", 32'(done), 32'd0);

    run_op("unk_f",   4'b1111, 32'd5,          32'd5,          1,  0,  32'd0,          1'b1);
    run_op("and_nz",  4'b0000, 32'h0000_00F0,  32'h0000_003C,  1,  0,  32'h0000_0030,  1'b0);
    run_op("unk_5",   4'b0101, 32'hFFFF_FFFF,  32'd1,          1,  0,  32'd0,          1'b1);
    run_op("add_pre", 4'b0010, 32'd5,          32'd7,          1,  0,  32'd12,         1'b0);

    // Reset in the middle of a 20-step shift aborts without a done pulse.
    ALUcontrol = 4'b0011; a = 32'd1; b = 32'd20; start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) dones++;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rsh_ready", 32'(ready), 32'd1);
    check("rsh_done", 32'(done), 32'd0);
    check("rsh_result", result, 32'd0);
    check("rsh_zero", 32'(zero), 32'd1);
    for (int i = 0; i < 30; i++) begin
      if (done) dones++;
      tick();
    end
    check("rsh_dones", 32'(dones), 32'd0);

    run_op("post_rst", 4'b0011, 32'h0000_0001, 32'd3,          4,  3,  32'h0000_0008,  1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
